// File: rtl/multicycle_cu.sv
// Multicycle RISC-V control unit: a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM
// that drives the datapath control lines, flags undecodable instructions and
// counts retired instructions (one per PCWrite pulse).
module multicycle_cu #(
    parameter int XLEN          = 32,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_UJ    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            BrEq,
    input  logic            BrLT,
    input  logic            mem_ready,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCSel,
    output logic [2:0]      ImmSel,
    output logic            ASel,
    output logic            BSel,
    output logic            BrUn,
    output logic [3:0]      ALUop,
    output logic            MemReq,
    output logic            MemRW,
    output logic            RegWEn,
    output logic [1:0]      WBSel,
    output logic            illegal,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   instret_reg;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       is_r, is_i, is_load, is_store, is_branch;
    logic       is_lui, is_auipc, is_jal, is_jalr;
    logic       legal, br_taken, mem_done;
    logic [2:0] imm_sel_dec;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Opcode classification; U/J opcodes only exist when that mode is built in,
    // and branch funct3 010/011 has no encoding.
    always_comb begin
        is_r      = (opcode == 7'b0110011);
        is_i      = (opcode == 7'b0010011);
        is_load   = (opcode == 7'b0000011);
        is_store  = (opcode == 7'b0100011);
        is_branch = (opcode == 7'b1100011) && (f3 != 3'b010) && (f3 != 3'b011);
        is_lui    = SUPPORT_UJ && (opcode == 7'b0110111);
        is_auipc  = SUPPORT_UJ && (opcode == 7'b0010111);
        is_jal    = SUPPORT_UJ && (opcode == 7'b1101111);
        is_jalr   = SUPPORT_UJ && (opcode == 7'b1100111);
        legal     = is_r || is_i || is_load || is_store || is_branch ||
                    is_lui || is_auipc || is_jal || is_jalr;

        imm_sel_dec = 3'd0;
        if (is_store)               imm_sel_dec = 3'd1;
        else if (is_branch)         imm_sel_dec = 3'd2;
        else if (is_lui || is_auipc) imm_sel_dec = 3'd3;
        else if (is_jal)            imm_sel_dec = 3'd4;

        case (f3)
            3'b000:  br_taken = BrEq;
            3'b001:  br_taken = !BrEq;
            3'b100,
            3'b110:  br_taken = BrLT;
            default: br_taken = !BrLT;
        endcase

        // Without the handshake the memory is assumed to finish in one cycle.
        mem_done = !MEM_HANDSHAKE || mem_ready;
    end

    // State register and retired-instruction counter (one count per PC update).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (PCWrite) begin
                instret_reg <= instret_reg + {{(XLEN-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and control outputs; everything is held low during reset.
    always_comb begin
        state_next = state_reg;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSel      = 1'b0;
        ImmSel     = 3'd0;
        ASel       = 1'b0;
        BSel       = 1'b0;
        BrUn       = 1'b0;
        ALUop      = 4'd0;
        MemReq     = 1'b0;
        MemRW      = 1'b0;
        RegWEn     = 1'b0;
        WBSel      = 2'd0;
        illegal    = 1'b0;
        state      = state_reg;
        instret    = instret_reg;

        case (state_reg)
            S_FETCH: begin
                IRWrite    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ImmSel = imm_sel_dec;
                if (!legal) begin
                    // Skip the instruction: advance PC to PC+4 and refetch.
                    illegal    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                ImmSel     = imm_sel_dec;
                state_next = S_WRITEBACK;
                if (is_r) begin
                    ALUop = {instr[30] & ((f3 == 3'b000) || (f3 == 3'b101)), f3};
                end else if (is_i) begin
                    BSel  = 1'b1;
                    ALUop = {instr[30] & (f3 == 3'b101), f3};
                end else if (is_load || is_store) begin
                    BSel       = 1'b1;
                    state_next = S_MEMORY;
                end else if (is_branch) begin
                    ASel       = 1'b1;
                    BSel       = 1'b1;
                    BrUn       = f3[1];
                    PCWrite    = 1'b1;
                    PCSel      = br_taken;
                    state_next = S_FETCH;
                end else if (is_lui) begin
                    BSel  = 1'b1;
                    ALUop = 4'b1001;
                end else if (is_auipc || is_jal) begin
                    ASel = 1'b1;
                    BSel = 1'b1;
                end else if (is_jalr) begin
                    BSel = 1'b1;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                // Address operands stay as in EXECUTE so ALU output remains valid.
                ImmSel = imm_sel_dec;
                BSel   = 1'b1;
                MemReq = 1'b1;
                MemRW  = is_store;
                if (mem_done) begin
                    if (is_store) begin
                        PCWrite    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                RegWEn     = 1'b1;
                PCWrite    = 1'b1;
                PCSel      = is_jal || is_jalr;
                state_next = S_FETCH;
                if (is_load)                WBSel = 2'd0;
                else if (is_jal || is_jalr) WBSel = 2'd2;
                else                        WBSel = 2'd1;
            end
            default: state_next = S_FETCH;
        endcase

        if (rst) begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
            PCSel   = 1'b0;
            ImmSel  = 3'd0;
            ASel    = 1'b0;
            BSel    = 1'b0;
            BrUn    = 1'b0;
            ALUop   = 4'd0;
            MemReq  = 1'b0;
            MemRW   = 1'b0;
            RegWEn  = 1'b0;
            WBSel   = 2'd0;
            illegal = 1'b0;
            state   = 3'd0;
            instret = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Testbench for multicycle_cu: a default build (XLEN=32, handshake, U/J) and a
// reduced build (XLEN=8, no handshake, no U/J) are exercised one at a time,
// the idle one held in reset. Per-cycle expectations go through a queue.
module tb_multicycle_cu;

    localparam int K_WB  = 0;
    localparam int K_BR  = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_ILL = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       irw, pcw, pcsel;
        logic [2:0] imm;
        logic       asel, bsel, brun;
        logic [3:0] alu;
        logic       mreq, mrw, regw;
        logic [1:0] wbs;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        ctl_t exp;
        logic ready;
    } cyc_t;

    typedef struct {
        logic [31:0] instr;
        int          kind;
        logic        asel, bsel;
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        brun, breq, brlt, br_pcsel;
        int          mem_cycles;
        bit          ready_never;
        logic [1:0]  wbsel;
        logic        wb_pcsel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] instr;
    logic        breq, brlt, mem_ready;
    logic        sel;

    logic irw_a, pcw_a, pcsel_a, asel_a, bsel_a, brun_a, mreq_a, mrw_a, regw_a, ill_a;
    logic irw_b, pcw_b, pcsel_b, asel_b, bsel_b, brun_b, mreq_b, mrw_b, regw_b, ill_b;
    logic [2:0]  imm_a, imm_b, st_a, st_b;
    logic [3:0]  alu_a, alu_b;
    logic [1:0]  wbs_a, wbs_b;
    logic [31:0] instret_a;
    logic [7:0]  instret_b;

    ctl_t ctl_a, ctl_b, got;
    cyc_t q[$];
    vec_t tab[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    multicycle_cu dut_a (
        .clk(clk), .rst(rst_a), .instr(instr), .BrEq(breq), .BrLT(brlt),
        .mem_ready(mem_ready), .IRWrite(irw_a), .PCWrite(pcw_a), .PCSel(pcsel_a),
        .ImmSel(imm_a), .ASel(asel_a), .BSel(bsel_a), .BrUn(brun_a), .ALUop(alu_a),
        .MemReq(mreq_a), .MemRW(mrw_a), .RegWEn(regw_a), .WBSel(wbs_a),
        .illegal(ill_a), .state(st_a), .instret(instret_a)
    );

    multicycle_cu #(.XLEN(8), .MEM_HANDSHAKE(1'b0), .SUPPORT_UJ(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .instr(instr), .BrEq(breq), .BrLT(brlt),
        .mem_ready(mem_ready), .IRWrite(irw_b), .PCWrite(pcw_b), .PCSel(pcsel_b),
        .ImmSel(imm_b), .ASel(asel_b), .BSel(bsel_b), .BrUn(brun_b), .ALUop(alu_b),
        .MemReq(mreq_b), .MemRW(mrw_b), .RegWEn(regw_b), .WBSel(wbs_b),
        .illegal(ill_b), .state(st_b), .instret(instret_b)
    );

    assign ctl_a = {st_a, irw_a, pcw_a, pcsel_a, imm_a, asel_a, bsel_a, brun_a,
                    alu_a, mreq_a, mrw_a, regw_a, wbs_a, ill_a};
    assign ctl_b = {st_b, irw_b, pcw_b, pcsel_b, imm_b, asel_b, bsel_b, brun_b,
                    alu_b, mreq_b, mrw_b, regw_b, wbs_b, ill_b};
    assign got   = sel ? ctl_b : ctl_a;

    function automatic vec_t mk(input logic [31:0] i, input int k,
                                input logic as, input logic bs, input logic [2:0] im,
                                input logic [3:0] al, input logic bu, input logic eq,
                                input logic lt, input logic bp, input int mc,
                                input bit rn, input logic [1:0] wb, input logic wp);
        vec_t v;
        v.instr = i;   v.kind = k;  v.asel = as; v.bsel = bs; v.imm = im;
        v.alu = al;    v.brun = bu; v.breq = eq; v.brlt = lt; v.br_pcsel = bp;
        v.mem_cycles = mc; v.ready_never = rn; v.wbsel = wb; v.wb_pcsel = wp;
        return v;
    endfunction

    task automatic chk_ctl(input string tag, input int cyc, input ctl_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ctl %s cyc%0d: got %06h required %06h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] actual, input logic [31:0] exp);
        n_checks++;
        if (actual !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, actual, exp);
        end
    endtask

    // Expand one instruction into its expected per-cycle outputs.
    task automatic push_vec(input vec_t v);
        ctl_t c;
        c = '0; c.st = 3'd0; c.irw = 1'b1;
        q.push_back({c, 1'b1});
        c = '0; c.st = 3'd1;
        if (v.kind == K_ILL) begin
            c.ill = 1'b1; c.pcw = 1'b1;
            q.push_back({c, 1'b1});
            return;
        end
        c.imm = v.imm;
        q.push_back({c, 1'b1});
        c = '0; c.st = 3'd2; c.asel = v.asel; c.bsel = v.bsel; c.imm = v.imm; c.alu = v.alu;
        if (v.kind == K_BR) begin
            c.brun = v.brun; c.pcw = 1'b1; c.pcsel = v.br_pcsel;
            q.push_back({c, 1'b1});
            return;
        end
        q.push_back({c, 1'b1});
        if (v.kind == K_LD || v.kind == K_ST) begin
            for (int k = 0; k < v.mem_cycles; k++) begin
                c = '0; c.st = 3'd3; c.mreq = 1'b1; c.mrw = (v.kind == K_ST);
                c.asel = v.asel; c.bsel = v.bsel; c.imm = v.imm; c.alu = v.alu;
                if (k == v.mem_cycles - 1 && v.kind == K_ST) c.pcw = 1'b1;
                q.push_back({c, v.ready_never ? 1'b0 : (k == v.mem_cycles - 1)});
            end
            if (v.kind == K_ST) return;
        end
        c = '0; c.st = 3'd4; c.regw = 1'b1; c.pcw = 1'b1; c.wbs = v.wbsel; c.pcsel = v.wb_pcsel;
        q.push_back({c, 1'b1});
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
    task automatic run_vec(input string tag, input vec_t v);
        int cyc = 0;
        instr = v.instr; breq = v.breq; brlt = v.brlt;
        push_vec(v);
        while (q.size() > 0) begin
            cyc_t it = q.pop_front();
            mem_ready = it.ready;
            #2;
            chk_ctl(tag, cyc, it.exp);
            cyc++;
            @(negedge clk);
        end
        exp_cnt++;
        if (sel) chk_val({tag, " instret"}, {24'd0, instret_b}, 32'(exp_cnt) & 32'hFF);
        else     chk_val({tag, " instret"}, instret_a, 32'(exp_cnt));
        $display("%s instr=%08h cycles=%0d instret=%0d", tag, v.instr, cyc, exp_cnt);
    endtask

    initial begin
        logic [2:0] rst_states [5];
        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        instr = 32'd0; breq = 1'b0; brlt = 1'b0; mem_ready = 1'b0;

        // Default build: kind, ASel, BSel, ImmSel, ALUop, BrUn, BrEq, BrLT,
        // branch PCSel, MEMORY cycles, ready-never, WBSel, WB PCSel
        tab.push_back(mk(32'h002081B3, K_WB, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // ADD
        tab.push_back(mk(32'h402081B3, K_WB, 0, 0, 3'd0, 4'b1000, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // SUB
        tab.push_back(mk(32'h4020D1B3, K_WB, 0, 0, 3'd0, 4'b1101, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // SRA
        tab.push_back(mk(32'hC0000093, K_WB, 0, 1, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // ADDI -1024
        tab.push_back(mk(32'h4030D093, K_WB, 0, 1, 3'd0, 4'b1101, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // SRAI
        tab.push_back(mk(32'h0000A283, K_LD, 0, 1, 3'd0, 4'b0000, 0, 0, 0, 0, 4, 0, 2'd0, 0)); // LW, 3 waits
        tab.push_back(mk(32'h0000A283, K_LD, 0, 1, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 0, 2'd0, 0)); // LW, ready at once
        tab.push_back(mk(32'h0050A223, K_ST, 0, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 3, 0, 2'd0, 0)); // SW, 2 waits
        tab.push_back(mk(32'h00208463, K_BR, 1, 1, 3'd2, 4'b0000, 0, 1, 0, 1, 0, 0, 2'd0, 0)); // BEQ eq
        tab.push_back(mk(32'h00209463, K_BR, 1, 1, 3'd2, 4'b0000, 0, 1, 0, 0, 0, 0, 2'd0, 0)); // BNE eq
        tab.push_back(mk(32'h0020C463, K_BR, 1, 1, 3'd2, 4'b0000, 0, 0, 1, 1, 0, 0, 2'd0, 0)); // BLT lt
        tab.push_back(mk(32'h0020D463, K_BR, 1, 1, 3'd2, 4'b0000, 0, 0, 1, 0, 0, 0, 2'd0, 0)); // BGE lt
        tab.push_back(mk(32'h0020D463, K_BR, 1, 1, 3'd2, 4'b0000, 0, 0, 0, 1, 0, 0, 2'd0, 0)); // BGE !lt
        tab.push_back(mk(32'h0020E463, K_BR, 1, 1, 3'd2, 4'b0000, 1, 0, 1, 1, 0, 0, 2'd0, 0)); // BLTU lt
        tab.push_back(mk(32'h0020F463, K_BR, 1, 1, 3'd2, 4'b0000, 1, 0, 1, 0, 0, 0, 2'd0, 0)); // BGEU lt
        tab.push_back(mk(32'h123450B7, K_WB, 0, 1, 3'd3, 4'b1001, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // LUI
        tab.push_back(mk(32'h12345097, K_WB, 1, 1, 3'd3, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd1, 0)); // AUIPC
        tab.push_back(mk(32'h008000EF, K_WB, 1, 1, 3'd4, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd2, 1)); // JAL
        tab.push_back(mk(32'h000100E7, K_WB, 0, 1, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd2, 1)); // JALR
        tab.push_back(mk(32'h0020A463, K_ILL, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // branch f3=010
        tab.push_back(mk(32'hFFFFFFFF, K_ILL, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0)); // bad opcode

        // Reset state of the default build.
        repeat (2) @(negedge clk);
        #2;
        chk_ctl("reset_a", 0, '0);
        chk_val("reset_a instret", instret_a, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            run_vec($sformatf("A%0d", i), tab[i]);
        end

        // Reset while a load waits in MEMORY: abort with no retire, no request.
        instr = 32'h0000A283; mem_ready = 1'b0;
        rst_states = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        for (int k = 0; k < 5; k++) begin
            #2;
            chk_val($sformatf("pre_rst state cyc%0d", k), {29'd0, got.st}, {29'd0, rst_states[k]});
            @(negedge clk);
        end
        rst_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 1);
            #2;
            chk_ctl("mid_mem_rst", k, '0);
            chk_val($sformatf("mid_mem_rst instret cyc%0d", k), instret_a, 32'd0);
            @(negedge clk);
        end
        rst_a = 1'b0;
        exp_cnt = 0;
        run_vec("A_after_rst", tab[0]);
        $display("mid-MEMORY reset sequence done");

        // Reduced build: no handshake, no U/J, 8-bit retire counter.
        rst_a = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        #2;
        chk_ctl("reset_b", 0, '0);
        @(negedge clk);
        rst_b = 1'b0;
        exp_cnt = 0;
        run_vec("B_lw", mk(32'h0000A283, K_LD, 0, 1, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 1, 2'd0, 0));
        run_vec("B_sw", mk(32'h0050A223, K_ST, 0, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 1, 1, 2'd0, 0));
        run_vec("B_jal", mk(32'h008000EF, K_ILL, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        run_vec("B_lui", mk(32'h123450B7, K_ILL, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        // Illegal skips advance the counter through 0xFF and wrap to 0x00.
        while (exp_cnt < 257) begin
            run_vec($sformatf("B_wrap%0d", exp_cnt),
                    mk(32'h00000000, K_ILL, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multicycle control unit for the RISC-V CPU: an explicit five-state FSM that sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath control lines for it. It is the parametrised successor of the five-cycle control unit:
- it supports variable instruction length (3–5+ cycles), a memory ready handshake and an optional U/J-type instruction mode;
- it adds illegal-opcode detection and a retired-instruction counter.

It sits between the instruction register/branch comparator and the datapath muxes, ALU, register file and data memory.

## Interface
- XLEN, 32: datapath width; sets retire-counter width.
- MEM_HANDSHAKE, 1: 1 = MEMORY state waits for mem_ready; 0 = MEMORY always lasts one cycle.
- SUPPORT_UJ, 1: 1 = LUI/AUIPC/JAL/JALR decoded; 0 = those opcodes are illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- instr  in  32  current instruction; stable from DECODE until instruction retires.
- BrEq  in  1  branch comparator equal.
- BrLT  in  1  branch comparator less-than (signedness per BrUn).
- mem_ready  in  1  data memory completed the access this cycle.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  update PC this cycle.
- PCSel  out  1  0 = PC+4, 1 = ALU result/ALUOut.
- ImmSel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- ASel  out  1  0 = rs1, 1 = PC.
- BSel  out  1  0 = rs2, 1 = immediate.
- BrUn  out  1  unsigned compare.
- ALUop  out  4  ALU operation.
- MemReq  out  1  data memory access request.
- MemRW  out  1  1 = write, 0 = read.
- RegWEn  out  1  register-file write enable.
- WBSel  out  2  0 = memory, 1 = ALU, 2 = PC+4.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state  out  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4.
- instret  out  XLEN  retired-instruction count.

## Operation
- All control outputs are combinational from state and instr. Each output is 0 in any cycle where it is not listed below.
- FETCH: IRWrite=1. Next state is DECODE.
- DECODE: ImmSel is set for the opcode. Transitions:
  - Illegal opcode → illegal=1, PCWrite=1, PCSel=0, next FETCH.
  - Otherwise → next EXECUTE.
- EXECUTE, by opcode:
  - R (0110011): ASel=0, BSel=0, ALUop={instr[30]&(f3==000|f3==101), f3}; next WRITEBACK.
  - I-ALU (0010011): BSel=1, ImmSel=0, ALUop={instr[30]&(f3==101), f3}; next WRITEBACK.
  - Load (0000011) and store (0100011): BSel=1, ALUop=0000, ImmSel=0 (load) or 1 (store); next MEMORY.
  - Branch (1100011): ASel=1, BSel=1, ImmSel=2, ALUop=0000, BrUn=f3[1], PCWrite=1, PCSel=taken; next FETCH.
    - taken: BEQ=BrEq, BNE=!BrEq, BLT/BLTU=BrLT, BGE/BGEU=!BrLT.
    - f3 of 010 or 011 is illegal (handled in DECODE).
  - LUI: BSel=1, ImmSel=3, ALUop=1001 (pass B).
  - AUIPC: ASel=1, BSel=1, ImmSel=3, ALUop=0000.
  - JAL: ASel=1, BSel=1, ImmSel=4, ALUop=0000.
  - JALR: BSel=1, ImmSel=0, ALUop=0000.
  - LUI, AUIPC, JAL and JALR all go next to WRITEBACK.
- MEMORY: MemReq=1, MemRW=1 for store, 0 for load; ASel/BSel/ImmSel/ALUop held as in EXECUTE.
  - Leave on mem_ready=1; with MEM_HANDSHAKE=0, leave unconditionally.
  - Store: PCWrite=1, PCSel=0 in the leaving cycle, next FETCH.
  - Load: next WRITEBACK.
- WRITEBACK: RegWEn=1, PCWrite=1, next FETCH.
  - WBSel: load=0; R/I/LUI/AUIPC=1; JAL/JALR=2.
  - PCSel=1 for JAL/JALR (target from datapath ALUOut), else 0.
- rd=x0 still asserts RegWEn; the register file discards the write.
- instret increments by 1 on every clock edge where PCWrite=1, including the illegal-skip cycle. It wraps from 2^XLEN−1 to 0.

## Timing
- Reset: while rst=1, state←FETCH and instret←0. All outputs are forced 0, including IRWrite. The first cycle after release is FETCH.
- rst asserted in any state, including MEMORY waiting on mem_ready, aborts the instruction with no PCWrite/RegWEn. Any pending memory request is dropped.
- Latency in cycles (F to last cycle inclusive):
  - branch: 3
  - store: 4+w
  - R/I/LUI/AUIPC/JAL/JALR: 4
  - load: 5+w
  - illegal: 2
  - w = extra MEMORY wait cycles.
- mem_ready is sampled only in MEMORY and ignored elsewhere. If mem_ready is already 1 on the first MEMORY cycle, MEMORY lasts 1 cycle.
- Exactly one PCWrite pulse per instruction. RegWEn is at most one cycle per instruction.

## Test plan
- Reset: hold rst 3 cycles mid-MEMORY → state=0, instret=0, all outputs 0; next cycle IRWrite=1.
- ADD then SUB (instr 0x002081B3, 0x402081B3) → states 0,1,2,4. ALUop 0000 then 1000. RegWEn=1 only in state 4. instret=2 after 8 cycles.
- LW with mem_ready low 3 cycles (MEM_HANDSHAKE=1) → MEMORY lasts 4 cycles, MemReq=1 and MemRW=0 throughout, WRITEBACK has WBSel=0; 8 cycles total. With MEM_HANDSHAKE=0 → 5 cycles.
- BGE with BrLT=1 → PCSel=0; with BrLT=0 → PCSel=1. Both cases give PCWrite in EXECUTE and a 3-cycle instruction. BLTU → BrUn=1.
- JAL with SUPPORT_UJ=1 → ImmSel=4 in EXECUTE; WRITEBACK shows WBSel=2, PCSel=1. With SUPPORT_UJ=0 → illegal=1 in DECODE, PCSel=0, 2-cycle instruction.
- instret preloaded/forced near 2^XLEN−1 (XLEN=8 build), two retires → 0xFF then 0x00.
